v810_busif: RTL and testbench

Multi-channel external bus interface unit for the V810 core. It arbitrates between NCH internal requesters (instruction fetch, data access, and optional extras such as a debug or DMA port) and runs V810-style bus cycles on the external pins. It adds two things the single-path memory unit lacks: selectable arbitration policy, and dynamic bus sizing that splits a 32-bit access into two halfword cycles on SZRQn. It sits between the execution/fetch units and the chip pins, in place of the fixed two-port memory unit.

---
 rtl/v810_pkg.sv | 22 ++
 rtl/v810_busarb.sv | 51 +++++
 rtl/v810_busif.sv | 235 +++++++++++++++++++++++
 tb/tb_v810_busif.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/v810_pkg.sv
// Shared types and constants for the V810 external bus interface.
// Bus cycle states, status codes and half-cycle helpers.
package v810_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_T1,
      S_T2,
      S_T1H,
      S_T2H
   } busif_state_t;

   localparam logic [1:0]  ST_IDLE     = 2'b00;
   localparam logic [3:0]  BEN_NONE    = 4'hF;
   localparam logic [31:0] HALF_OFFSET = 32'd2;

   // Upper-halfword lanes move onto the low 16 data pins.
   function automatic logic [3:0] half_ben(input logic [3:0] be);
      return ~{2'b00, be[3:2]};
   endfunction

endpackage

// File: rtl/v810_busarb.sv
// Channel winner select for the V810 bus interface.
// Fixed priority (lowest index) or round-robin from last grant + 1.
module v810_busarb
   import v810_pkg::*;
#(
   parameter int NCH    = 2,
   parameter int ARB_RR = 0,
   localparam int IW    = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           ce,
   input  logic [NCH-1:0] req,
   input  logic           take,
   output logic           valid,
   output logic [IW-1:0]  idx
);

   logic [IW-1:0] ptr_q;
   logic [IW-1:0] ptr_d;

   // Search eligible requests starting at the policy's base slot.
   always_comb begin
      int base;
      int j;
      valid = 1'b0;
      idx   = '0;
      base  = (ARB_RR != 0) ? int'(ptr_q) + 1 : 0;
      for (int i = 0; i < NCH; i++) begin
         j = (base + i) % NCH;
         if (!valid && req[j]) begin
            valid = 1'b1;
            idx   = IW'(j);
         end
      end
      ptr_d = ptr_q;
      if (ARB_RR != 0 && take && valid) begin
         ptr_d = idx;
      end
   end

   // Round-robin pointer; starts at NCH-1 so channel 0 wins first.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= IW'(NCH - 1);
      end else if (ce) begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/v810_busif.sv
// V810 multi-channel external bus interface unit.
// Arbitrates requesters and runs bus cycles with 16-bit dynamic sizing.
module v810_busif
   import v810_pkg::*;
#(
   parameter int NCH    = 2,
   parameter int ARB_RR = 0
) (
   input  logic             CLK,
   input  logic             RES,
   input  logic             CE,
   input  logic [NCH-1:0]   REQ,
   output logic [NCH-1:0]   ACK,
   input  logic [NCH*32-1:0] CA,
   input  logic [NCH-1:0]   CWR,
   input  logic [NCH*4-1:0] CBE,
   input  logic [NCH*2-1:0] CST,
   input  logic [NCH*32-1:0] CDO,
   output logic [31:0]      RDATA,
   output logic [31:0]      A,
   input  logic [31:0]      D_I,
   output logic [31:0]      D_O,
   output logic [3:0]       BEn,
   output logic [1:0]       ST,
   output logic             DAn,
   output logic             RW,
   output logic             BCYSTn,
   input  logic             READYn,
   input  logic             SZRQn
);

   localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

   busif_state_t state_q, state_d;
   logic [IW-1:0]  idx_q, idx_d;
   logic [31:0]    addr_q, addr_d;
   logic           wr_q, wr_d;
   logic [3:0]     be_q, be_d;
   logic [1:0]     tst_q, tst_d;
   logic [31:0]    wd_q, wd_d;
   logic [NCH-1:0] ack_q, ack_d;
   logic [31:0]    rdata_q, rdata_d;
   logic [31:0]    a_q, a_d;
   logic [31:0]    do_q, do_d;
   logic [3:0]     ben_q, ben_d;
   logic [1:0]     bst_q, bst_d;
   logic           dan_q, dan_d;
   logic           rw_q, rw_d;
   logic           bcyst_q, bcyst_d;

   logic [NCH-1:0] elig;
   logic           take;
   logic           arb_valid;
   logic [IW-1:0]  arb_idx;
   logic [31:0]    sel_ca;
   logic           sel_wr;
   logic [3:0]     sel_be;
   logic [1:0]     sel_st;
   logic [31:0]    sel_do;

   // A channel being acknowledged this cycle cannot win again yet.
   assign elig = REQ & ~ack_q;
   assign take = (state_q == S_IDLE);

   v810_busarb #(
      .NCH    (NCH),
      .ARB_RR (ARB_RR)
   ) u_arb (
      .clk   (CLK),
      .rst   (RES),
      .ce    (CE),
      .req   (elig),
      .take  (take),
      .valid (arb_valid),
      .idx   (arb_idx)
   );

   // Mux the winning channel's transaction fields.
   always_comb begin
      sel_ca = '0;
      sel_wr = 1'b0;
      sel_be = '0;
      sel_st = '0;
      sel_do = '0;
      for (int i = 0; i < NCH; i++) begin
         if (arb_idx == IW'(i)) begin
            sel_ca = CA[i*32 +: 32];
            sel_wr = CWR[i];
            sel_be = CBE[i*4 +: 4];
            sel_st = CST[i*2 +: 2];
            sel_do = CDO[i*32 +: 32];
         end
      end
   end

   // Bus cycle sequencing; outputs computed for the next state.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      addr_d  = addr_q;
      wr_d    = wr_q;
      be_d    = be_q;
      tst_d   = tst_q;
      wd_d    = wd_q;
      ack_d   = '0;
      rdata_d = rdata_q;
      a_d     = a_q;
      do_d    = do_q;
      ben_d   = ben_q;
      bst_d   = bst_q;
      dan_d   = dan_q;
      rw_d    = rw_q;
      bcyst_d = 1'b1;
      unique case (state_q)
         S_IDLE: begin
            dan_d = 1'b1;
            ben_d = BEN_NONE;
            rw_d  = 1'b1;
            bst_d = ST_IDLE;
            if (arb_valid) begin
               idx_d   = arb_idx;
               addr_d  = sel_ca & ~32'h3;
               wr_d    = sel_wr;
               be_d    = sel_be;
               tst_d   = sel_st;
               wd_d    = sel_do;
               state_d = S_T1;
               a_d     = addr_d;
               ben_d   = ~sel_be;
               bst_d   = sel_st;
               rw_d    = ~sel_wr;
               dan_d   = 1'b0;
               bcyst_d = 1'b0;
               if (sel_wr) begin
                  do_d = sel_do;
               end
            end
         end
         S_T1: begin
            state_d = S_T2;
         end
         S_T2: begin
            if (!READYn) begin
               if (SZRQn || be_q[3:2] == 2'b00) begin
                  if (!wr_q) begin
                     rdata_d = D_I;
                  end
                  ack_d[idx_q] = 1'b1;
                  state_d      = S_IDLE;
                  dan_d        = 1'b1;
                  ben_d        = BEN_NONE;
                  rw_d         = 1'b1;
                  bst_d        = ST_IDLE;
               end else begin
                  rdata_d[15:0] = D_I[15:0];
                  state_d       = S_T1H;
                  a_d           = addr_q + HALF_OFFSET;
                  ben_d         = half_ben(be_q);
                  bcyst_d       = 1'b0;
                  if (wr_q) begin
                     do_d = {wd_q[31:16], wd_q[31:16]};
                  end
               end
            end
         end
         S_T1H: begin
            state_d = S_T2H;
         end
         S_T2H: begin
            if (!READYn) begin
               rdata_d[31:16] = D_I[15:0];
               ack_d[idx_q]   = 1'b1;
               state_d        = S_IDLE;
               dan_d          = 1'b1;
               ben_d          = BEN_NONE;
               rw_d           = 1'b1;
               bst_d          = ST_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and registered bus outputs; CE low freezes everything.
   always_ff @(posedge CLK) begin
      if (RES) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         addr_q  <= '0;
         wr_q    <= 1'b0;
         be_q    <= '0;
         tst_q   <= '0;
         wd_q    <= '0;
         ack_q   <= '0;
         rdata_q <= '0;
         a_q     <= '0;
         do_q    <= '0;
         ben_q   <= BEN_NONE;
         bst_q   <= ST_IDLE;
         dan_q   <= 1'b1;
         rw_q    <= 1'b1;
         bcyst_q <= 1'b1;
      end else if (CE) begin
         state_q <= state_d;
         idx_q   <= idx_d;
         addr_q  <= addr_d;
         wr_q    <= wr_d;
         be_q    <= be_d;
         tst_q   <= tst_d;
         wd_q    <= wd_d;
         ack_q   <= ack_d;
         rdata_q <= rdata_d;
         a_q     <= a_d;
         do_q    <= do_d;
         ben_q   <= ben_d;
         bst_q   <= bst_d;
         dan_q   <= dan_d;
         rw_q    <= rw_d;
         bcyst_q <= bcyst_d;
      end
   end

   assign ACK    = ack_q;
   assign RDATA  = rdata_q;
   assign A      = a_q;
   assign D_O    = do_q;
   assign BEn    = ben_q;
   assign ST     = bst_q;
   assign DAn    = dan_q;
   assign RW     = rw_q;
   assign BCYSTn = bcyst_q;

endmodule

// File: tb/tb_v810_busif.sv
// Directed bench for v810_busif: fixed-priority and round-robin instances.
// Each task drives a scenario cycle by cycle and checks inline.
module tb_v810_busif;

   logic        clk = 1'b0;
   logic        res;
   logic        ce;
   logic        readyn;
   logic        szrqn;
   logic [31:0] d_i;

   logic [1:0]  f_req;
   logic [1:0]  f_ack;
   logic [63:0] f_ca;
   logic [1:0]  f_cwr;
   logic [7:0]  f_cbe;
   logic [3:0]  f_cst;
   logic [63:0] f_cdo;
   logic [31:0] f_rdata;
   logic [31:0] f_a;
   logic [31:0] f_do;
   logic [3:0]  f_ben;
   logic [1:0]  f_st;
   logic        f_dan;
   logic        f_rw;
   logic        f_bcy;

   logic [2:0]  r_req;
   logic [2:0]  r_ack;
   logic [95:0] r_ca;
   logic [2:0]  r_cwr;
   logic [11:0] r_cbe;
   logic [5:0]  r_cst;
   logic [95:0] r_cdo;
   logic [31:0] r_rdata;
   logic [31:0] r_a;
   logic [31:0] r_do;
   logic [3:0]  r_ben;
   logic [1:0]  r_st;
   logic        r_dan;
   logic        r_rw;
   logic        r_bcy;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   v810_busif #(.NCH(2), .ARB_RR(0)) u_fp (
      .CLK(clk), .RES(res), .CE(ce),
      .REQ(f_req), .ACK(f_ack),
      .CA(f_ca), .CWR(f_cwr), .CBE(f_cbe),
      .CST(f_cst), .CDO(f_cdo), .RDATA(f_rdata),
      .A(f_a), .D_I(d_i), .D_O(f_do),
      .BEn(f_ben), .ST(f_st), .DAn(f_dan),
      .RW(f_rw), .BCYSTn(f_bcy),
      .READYn(readyn), .SZRQn(szrqn)
   );

   v810_busif #(.NCH(3), .ARB_RR(1)) u_rr (
      .CLK(clk), .RES(res), .CE(ce),
      .REQ(r_req), .ACK(r_ack),
      .CA(r_ca), .CWR(r_cwr), .CBE(r_cbe),
      .CST(r_cst), .CDO(r_cdo), .RDATA(r_rdata),
      .A(r_a), .D_I(d_i), .D_O(r_do),
      .BEn(r_ben), .ST(r_st), .DAn(r_dan),
      .RW(r_rw), .BCYSTn(r_bcy),
      .READYn(readyn), .SZRQn(szrqn)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      res = 1'b1;
      cyc();
      cyc();
      res = 1'b0;
      cyc();
      checks++;
      if (f_ack !== 2'b00) begin
         errors++;
         $display("FAIL reset_ack got %b want 00", f_ack);
      end
      checks++;
      if (f_rdata !== 32'h0 || f_a !== 32'h0 || f_do !== 32'h0) begin
         errors++;
         $display("FAIL reset_data got rd=%h a=%h do=%h want 0",
                  f_rdata, f_a, f_do);
      end
      checks++;
      if (f_ben !== 4'hF || f_st !== 2'b00) begin
         errors++;
         $display("FAIL reset_ben got ben=%h st=%b want F/00",
                  f_ben, f_st);
      end
      checks++;
      if (f_dan !== 1'b1 || f_rw !== 1'b1 || f_bcy !== 1'b1) begin
         errors++;
         $display("FAIL reset_strobes got dan=%b rw=%b bcy=%b want 111",
                  f_dan, f_rw, f_bcy);
      end
      checks++;
      if (r_ack !== 3'b000 || r_dan !== 1'b1) begin
         errors++;
         $display("FAIL reset_rr got ack=%b dan=%b want 000/1",
                  r_ack, r_dan);
      end
   endtask

   task automatic test_fixed_prio();
      logic [1:0] exp_ack;
      f_ca[31:0]  = 32'h0000_0100;
      f_ca[63:32] = 32'h0000_0200;
      f_cwr = 2'b00;
      f_cbe = 8'hFF;
      f_cst = 4'b0000;
      readyn = 1'b0;
      szrqn  = 1'b1;
      d_i    = 32'h1111_2222;
      f_req  = 2'b11;
      for (int c = 1; c <= 8; c++) begin
         if (c > 1) cyc();
         if (c == 5) d_i = 32'h3333_4444;
         exp_ack = (c == 4) ? 2'b01 : (c == 7) ? 2'b10 : 2'b00;
         checks++;
         if (f_ack !== exp_ack) begin
            errors++;
            $display("FAIL fp_ack c%0d got %b want %b", c, f_ack, exp_ack);
         end
         checks++;
         if (f_bcy !== ((c == 2 || c == 5) ? 1'b0 : 1'b1)) begin
            errors++;
            $display("FAIL fp_bcystn c%0d got %b", c, f_bcy);
         end
         if (c == 2 || c == 5) begin
            checks++;
            if (f_a !== ((c == 2) ? 32'h100 : 32'h200)) begin
               errors++;
               $display("FAIL fp_addr c%0d got %h", c, f_a);
            end
         end
         if (c == 4 || c == 7) begin
            checks++;
            if (f_rdata !== ((c == 4) ? 32'h1111_2222 : 32'h3333_4444)) begin
               errors++;
               $display("FAIL fp_rdata c%0d got %h", c, f_rdata);
            end
         end
         f_req = f_req & ~f_ack;
      end
   endtask

   task automatic test_round_robin();
      int order [4];
      int n;
      logic [2:0] prev;
      n = 0;
      prev = 3'b000;
      readyn = 1'b0;
      szrqn  = 1'b1;
      r_req  = 3'b111;
      for (int c = 1; c <= 20 && n < 4; c++) begin
         if (c > 1) cyc();
         if (r_ack !== 3'b000) begin
            checks++;
            if ($countones(r_ack) != 1 || prev !== 3'b000) begin
               errors++;
               $display("FAIL rr_pulse c%0d got %b prev %b", c, r_ack, prev);
            end
            for (int i = 0; i < 3; i++) begin
               if (r_ack[i]) order[n] = i;
            end
            n++;
         end
         prev = r_ack;
      end
      r_req = 3'b000;
      checks++;
      if (n != 4) begin
         errors++;
         $display("FAIL rr_timeout got %0d grants want 4", n);
      end else begin
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (order[k] != ((k == 3) ? 0 : k)) begin
               errors++;
               $display("FAIL rr_order k%0d got %0d want %0d",
                        k, order[k], (k == 3) ? 0 : k);
            end
         end
      end
      for (int c = 0; c < 5; c++) cyc();
   endtask

   task automatic test_split_read();
      f_ca[31:0] = 32'h0500_0004;
      f_cwr[0]   = 1'b0;
      f_cbe[3:0] = 4'hF;
      f_cst[1:0] = 2'b10;
      readyn = 1'b0;
      szrqn  = 1'b0;
      f_req  = 2'b01;
      for (int c = 1; c <= 6; c++) begin
         if (c > 1) cyc();
         d_i = (c >= 4) ? 32'h7777_ABCD : 32'h5555_1234;
         if (c == 2) begin
            checks++;
            if (f_a !== 32'h0500_0004 || f_ben !== 4'h0 ||
                f_st !== 2'b10 || f_rw !== 1'b1) begin
               errors++;
               $display("FAIL sr_t1 got a=%h ben=%b st=%b rw=%b",
                        f_a, f_ben, f_st, f_rw);
            end
         end
         if (c == 4) begin
            checks++;
            if (f_a !== 32'h0500_0006 || f_ben !== 4'b1100 ||
                f_bcy !== 1'b0) begin
               errors++;
               $display("FAIL sr_t1h got a=%h ben=%b bcy=%b want 05000006/1100/0",
                        f_a, f_ben, f_bcy);
            end
         end
         if (c == 5) begin
            checks++;
            if (f_ack !== 2'b00 || f_dan !== 1'b0) begin
               errors++;
               $display("FAIL sr_t2h got ack=%b dan=%b", f_ack, f_dan);
            end
         end
         if (c == 6) begin
            checks++;
            if (f_ack !== 2'b01 || f_rdata !== 32'hABCD_1234) begin
               errors++;
               $display("FAIL sr_done got ack=%b rd=%h want 01/ABCD1234",
                        f_ack, f_rdata);
            end
            f_req = 2'b00;
         end
      end
      szrqn = 1'b1;
      cyc();
   endtask

   task automatic test_split_write();
      f_ca[31:0]  = 32'h0000_0040;
      f_cwr[0]    = 1'b1;
      f_cdo[31:0] = 32'hDEAD_BEEF;
      f_cst[1:0]  = 2'b01;
      readyn = 1'b0;
      szrqn  = 1'b0;
      f_cbe[3:0] = 4'h3;
      f_req = 2'b01;
      for (int c = 1; c <= 4; c++) begin
         if (c > 1) cyc();
         if (c == 2) begin
            checks++;
            if (f_ben !== 4'b1100 || f_do !== 32'hDEAD_BEEF ||
                f_rw !== 1'b0) begin
               errors++;
               $display("FAIL sw_lo got ben=%b do=%h rw=%b", f_ben, f_do, f_rw);
            end
         end
         if (c == 4) begin
            checks++;
            if (f_ack !== 2'b01 || f_ben !== 4'hF || f_bcy !== 1'b1) begin
               errors++;
               $display("FAIL sw_nosplit got ack=%b ben=%b bcy=%b",
                        f_ack, f_ben, f_bcy);
            end
            f_req = 2'b00;
         end
      end
      cyc();
      f_cbe[3:0] = 4'hF;
      f_req = 2'b01;
      for (int c = 1; c <= 6; c++) begin
         if (c > 1) cyc();
         if (c == 4) begin
            checks++;
            if (f_do !== 32'hDEAD_DEAD || f_ben !== 4'b1100 ||
                f_a !== 32'h0000_0042) begin
               errors++;
               $display("FAIL sw_hi got do=%h ben=%b a=%h", f_do, f_ben, f_a);
            end
         end
         if (c == 6) begin
            checks++;
            if (f_ack !== 2'b01) begin
               errors++;
               $display("FAIL sw_hi_ack got %b want 01", f_ack);
            end
            f_req = 2'b00;
         end
      end
      szrqn = 1'b1;
      f_cwr[0] = 1'b0;
      cyc();
   endtask

   task automatic test_wait_ce();
      f_ca[31:0] = 32'h0000_0080;
      f_cwr[0]   = 1'b0;
      f_cbe[3:0] = 4'hF;
      szrqn = 1'b1;
      d_i   = 32'hCAFE_F00D;
      f_req = 2'b01;
      for (int c = 1; c <= 9; c++) begin
         if (c > 1) cyc();
         ce = (c == 4 || c == 5) ? 1'b0 : 1'b1;
         readyn = (c == 4 || c == 5 || c >= 8) ? 1'b0 : 1'b1;
         checks++;
         if (f_ack !== ((c == 9) ? 2'b01 : 2'b00)) begin
            errors++;
            $display("FAIL wt_ack c%0d got %b", c, f_ack);
         end
         if (c >= 2 && c <= 8) begin
            checks++;
            if (f_dan !== 1'b0) begin
               errors++;
               $display("FAIL wt_dan c%0d got %b want 0", c, f_dan);
            end
         end
         if (c == 9) begin
            checks++;
            if (f_rdata !== 32'hCAFE_F00D) begin
               errors++;
               $display("FAIL wt_rdata got %h want CAFEF00D", f_rdata);
            end
            f_req = 2'b00;
         end
      end
      ce = 1'b1;
      cyc();
   endtask

   task automatic test_reset_mid();
      f_ca[31:0] = 32'h0000_00C0;
      f_cwr[0]   = 1'b0;
      f_cbe[3:0] = 4'hF;
      f_req = 2'b01;
      for (int c = 1; c <= 8; c++) begin
         if (c > 1) cyc();
         res = (c == 4);
         readyn = (c >= 6) ? 1'b0 : 1'b1;
         checks++;
         if (f_ack !== ((c == 8) ? 2'b01 : 2'b00)) begin
            errors++;
            $display("FAIL rm_ack c%0d got %b", c, f_ack);
         end
         if (c == 5) begin
            checks++;
            if (f_dan !== 1'b1 || f_ben !== 4'hF || f_bcy !== 1'b1) begin
               errors++;
               $display("FAIL rm_abort got dan=%b ben=%b bcy=%b",
                        f_dan, f_ben, f_bcy);
            end
         end
         if (c == 6) begin
            checks++;
            if (f_bcy !== 1'b0 || f_a !== 32'h0000_00C0) begin
               errors++;
               $display("FAIL rm_regrant got bcy=%b a=%h", f_bcy, f_a);
            end
         end
         if (c == 8) f_req = 2'b00;
      end
      cyc();
   endtask

   initial begin
      res = 1'b1;
      ce  = 1'b1;
      readyn = 1'b1;
      szrqn  = 1'b1;
      d_i   = '0;
      f_req = '0;
      f_ca  = '0;
      f_cwr = '0;
      f_cbe = '0;
      f_cst = '0;
      f_cdo = '0;
      r_req = '0;
      r_ca  = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
      r_cwr = '0;
      r_cbe = 12'hFFF;
      r_cst = '0;
      r_cdo = '0;
      test_reset();
      test_fixed_prio();
      test_round_robin();
      test_split_read();
      test_split_write();
      test_wait_ce();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

endmodule
